// File: rtl/mux_scan_sequencer.sv
// Steps an 8:1 mux select 0..7 with a div+1 cycle dwell and packs the sampled bits into a byte.
// Latency 1 + 8*(div_q+1) cycles from start to valid; MUX_SCAN_CONT_EN rescans back to back.
// Backpressure: data/valid hold in DONE until valid&&ready; start is ignored while busy.
module mux_scan_sequencer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] div,
   input  logic             o_in,
   output logic [2:0]       s,
   output logic [7:0]       data,
   output logic             valid,
   input  logic             ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic [7:0]       cap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= 3'd0;
         data  <= 8'd0;
         valid <= 1'b0;
         busy  <= 1'b0;
         cnt   <= '0;
         div_q <= '0;
         cap   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  div_q <= div;
                  cnt   <= div;
                  s     <= 3'd0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (cnt != '0) begin
                  cnt <= cnt - DIV_W'(1);
               end else begin
                  cap[s] <= o_in;
                  if (s != 3'd7) begin
                     s   <= s + 3'd1;
                     cnt <= div_q;
                  end else begin
                     // The last bit lands in cap on this same edge, so merge it directly.
                     data  <= {o_in, cap[6:0]};
                     valid <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (valid && ready) begin
                  valid <= 1'b0;
                  s     <= 3'd0;
`ifdef MUX_SCAN_CONT_EN
                  cnt   <= div_q;
                  state <= SCAN;
`else
                  busy  <= 1'b0;
                  state <= IDLE;
`endif
               end
            end
            default: begin
               state <= IDLE;
               s     <= 3'd0;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: stimulus pushes expected byte and latency, a negedge monitor pops on each new valid.
// Under MUX_SCAN_CONT_EN only the free-running scan scenario is exercised.
module tb_mux_scan_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] div;
   logic       o_in;
   logic [2:0] s;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       busy;

   logic [7:0] mux_data;
   int         n_tests;
   int         n_fail;
   int         cyc;
   int         ref_cyc;
   bit         seen;
   logic [7:0] exp_data_q[$];
   int         exp_lat_q[$];

   mux_scan_sequencer #(.DIV_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .div   (div),
      .o_in  (o_in),
      .s     (s),
      .data  (data),
      .valid (valid),
      .ready (ready),
      .busy  (busy)
   );

   assign o_in = mux_data[s];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each new valid must match the oldest scoreboard entry in data and latency.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else begin
         if (valid && !seen) begin
            seen = 1'b1;
            if (exp_data_q.size() == 0) begin
               check("unexpected_valid", 32'(data), 32'hFFFF_FFFF);
            end else begin
               check("sb_data", 32'(data), 32'(exp_data_q.pop_front()));
               check("sb_latency", 32'(cyc - ref_cyc), 32'(exp_lat_q.pop_front()));
            end
         end
         if (!valid)
            seen = 1'b0;
`ifdef MUX_SCAN_CONT_EN
         if (valid && ready)
            ref_cyc = cyc;
`endif
      end
   end

   task automatic expect_byte(input logic [7:0] d, input int lat);
      exp_data_q.push_back(d);
      exp_lat_q.push_back(lat);
   endtask

   task automatic do_start(input logic [7:0] d);
      @(negedge clk);
      div     = d;
      start   = 1'b1;
      ref_cyc = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy && !valid) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_s(input string name, input logic [2:0] val, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (s == val) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_valid(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (valid) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s"},     32'(s),     32'd0);
      check({tag, "_data"},  32'(data),  32'd0);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_busy"},  32'(busy),  32'd0);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      ref_cyc  = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      div      = 8'd0;
      ready    = 1'b1;
      mux_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef MUX_SCAN_CONT_EN
      // Free-running scan: each later byte follows its handshake edge by 8*(div+1) cycles.
      mux_data = 8'hC3;
      for (int k = 0; k < 5; k++)
         expect_byte(8'hC3, 9);
      do_start(8'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (exp_data_q.size() == 0)
            break;
      end
      check("cont_drain", 32'(exp_data_q.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("cont_reset");
      repeat (20) @(negedge clk);
      check("cont_stays_reset", 32'(valid | busy), 32'd0);
`else
      // 1: div=0, select walks one value per cycle.
      mux_data = 8'hA5;
      expect_byte(8'hA5, 9);
      do_start(8'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("t1_s%0d", k), 32'(s), 32'(k));
      end
      wait_idle("t1_idle", 20);
      check("t1_s_idle", 32'(s), 32'd0);
      check("t1_data_hold", 32'(data), 32'hA5);

      // 2: div=3, each select held 4 cycles.
      mux_data = 8'h3C;
      expect_byte(8'h3C, 33);
      do_start(8'd3);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         check($sformatf("t2_s_c%0d", i), 32'(s), 32'(i / 4));
      end
      wait_idle("t2_idle", 20);

      // 3: consumer stall of 10 cycles with a start pulse in the middle.
      mux_data = 8'h81;
      ready    = 1'b0;
      expect_byte(8'h81, 17);
      do_start(8'd1);
      wait_valid("t3_valid_seen", 40);
      for (int i = 0; i < 10; i++) begin
         check("t3_valid_hold", 32'(valid), 32'd1);
         check("t3_data_hold", 32'(data), 32'h81);
         check("t3_s_hold", 32'(s), 32'd7);
         if (i == 4) begin
            mux_data = 8'h00;
            start    = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
      end
      ready = 1'b1;
      @(negedge clk);
      check("t3_valid_drop", 32'(valid), 32'd0);
      check("t3_busy_drop", 32'(busy), 32'd0);
      repeat (30) @(negedge clk);
      check("t3_no_rescan", 32'(busy), 32'd0);

      // 4: reset while s==4 aborts; no byte may appear afterwards.
      mux_data = 8'hFF;
      do_start(8'd2);
      wait_s("t4_reach_s4", 3'd4, 40);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t4_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("t4_no_resume", 32'(busy), 32'd0);
      mux_data = 8'h5A;
      expect_byte(8'h5A, 9);
      do_start(8'd0);
      wait_idle("t4_idle", 20);

      // 5: div and mux data change mid-scan.
      mux_data = 8'h0F;
      expect_byte(8'hEF, 25);
      do_start(8'd2);
      div = 8'd0;
      wait_s("t5_reach_s5", 3'd5, 40);
      mux_data = 8'hF0;
      wait_idle("t5_idle", 40);
`endif

      repeat (3) @(negedge clk);
      check("sb_drain", 32'(exp_data_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
